bot_state_writer: RTL and testbench

- Transmit side of the bot mailbox protocol. The existing reader polls a per-bot slot flag; on 'w' it consumes vx, vy, x and y, then rewrites the flag to 'r'.
- This block collects per-bot state records in Q5.11 (value × 2^11, 16-bit two's complement). When a slot is free it serialises the record onto a word-write bus, data words first and flag 'w' last (commit).
- It sits between the trajectory/velocity compute logic and the mailbox storage that the reader drains.

---
 rtl/bot_mbox_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 61 ++++++
 rtl/bot_state_writer.sv | 250 +++++++++++++++++++++++++
 tb/tb_bot_state_writer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bot_mbox_pkg.sv
// Shared definitions for the bot mailbox transmit path: word indices inside a
// bot slot, flag encodings, fixed-point format and the writer FSM states.
`timescale 1ns/1ps
package bot_mbox_pkg;

    // Word index within a bot slot (low three bits of the bus address).
    localparam logic [2:0] WORD_FLAG = 3'd0;
    localparam logic [2:0] WORD_VX   = 3'd1;
    localparam logic [2:0] WORD_VY   = 3'd2;
    localparam logic [2:0] WORD_X    = 3'd3;
    localparam logic [2:0] WORD_Y    = 3'd4;

    // Flag encodings: 'w' = record written and ready, 'r' = reader has consumed it.
    localparam logic [15:0] FLAG_W = 16'h0077;
    localparam logic [15:0] FLAG_R = 16'h0072;

    // Q5.11: value scaled by 2^11 in a 16-bit two's complement word.
    localparam int Q_FRAC = 11;

    // Writer FSM: data words first, flag word last so the reader only ever
    // sees a complete record.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_VX  = 3'd1,
        ST_WR_VY  = 3'd2,
        ST_WR_X   = 3'd3,
        ST_WR_Y   = 3'd4,
        ST_COMMIT = 3'd5
    } wr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over up to 8 requesters. The pointer holds the index
// where the next search begins; after a grant to g it moves to g+1, so the
// bot that just won becomes the lowest priority.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic         gnt_valid,
    output logic [2:0]   gnt_idx
);

    logic [2:0]     ptr_q;
    logic [2:0]     ptr_d;
    logic [2*N-1:0] req_rot;
    logic [3:0]     pos;
    logic [3:0]     nxt;

    // Pick the first requester at or after the pointer, wrapping modulo N.
    always_comb begin
        req_rot   = {req, req} >> ptr_q;
        gnt_valid = 1'b0;
        gnt_idx   = 3'd0;
        pos       = 4'd0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pos = {1'b0, ptr_q} + 4'(k);
                if (pos >= 4'(N)) begin
                    pos = pos - 4'(N);
                end
                gnt_valid = 1'b1;
                gnt_idx   = pos[2:0];
            end
        end
    end

    // Move the search start just past the bot that was granted.
    always_comb begin
        ptr_d = ptr_q;
        nxt   = {1'b0, gnt_idx} + 4'd1;
        if (nxt >= 4'(N)) begin
            nxt = 4'd0;
        end
        if (adv && gnt_valid) begin
            ptr_d = nxt[2:0];
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 3'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bot_state_writer.sv
// Transmit side of the bot mailbox. Holds one Q5.11 state record per bot and,
// once that bot's slot has been drained by the reader, writes vx, vy, x, y and
// finally the 'w' flag onto a word-write bus.
// Optional build macro: BOT_VEL_CLAMP_EN saturates vx/vy to [-VMAX, +VMAX]
// when a record is latched; without it all words pass through bit-exact.
`timescale 1ns/1ps
module bot_state_writer
    import bot_mbox_pkg::*;
#(
    parameter int                NUM_BOTS = 3,
    parameter int                WORD_W   = 16,
    parameter logic [WORD_W-1:0] VMAX     = 'h1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_BOTS-1:0]     upd_valid,
    output logic [NUM_BOTS-1:0]     upd_ready,
    input  logic [NUM_BOTS*64-1:0]  upd_data,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [5:0]              wr_addr,
    output logic [WORD_W-1:0]       wr_data,
    input  logic [NUM_BOTS-1:0]     slot_consumed,
    output logic                    write_done,
    output logic [2:0]              done_bot,
    output logic                    proto_err
);

    localparam int REC_W = 4 * WORD_W;

    // Record layout: {vx, vy, x, y}, vx in the MSBs.
    function automatic logic [WORD_W-1:0] rec_word(input logic [REC_W-1:0] rec,
                                                   input logic [2:0] idx);
        logic [WORD_W-1:0] w;
        case (idx)
            WORD_VX: w = rec[4*WORD_W-1:3*WORD_W];
            WORD_VY: w = rec[3*WORD_W-1:2*WORD_W];
            WORD_X:  w = rec[2*WORD_W-1:WORD_W];
            WORD_Y:  w = rec[WORD_W-1:0];
            default: w = WORD_W'(FLAG_W);
        endcase
        return w;
    endfunction

`ifdef BOT_VEL_CLAMP_EN
    function automatic logic [WORD_W-1:0] clamp_vel(input logic [WORD_W-1:0] v);
        logic signed [WORD_W-1:0] sv;
        logic signed [WORD_W-1:0] hi;
        logic signed [WORD_W-1:0] lo;
        sv = v;
        hi = VMAX;
        lo = -hi;
        if (sv > hi) begin
            return hi;
        end else if (sv < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic [REC_W-1:0] latch_rec(input logic [REC_W-1:0] r);
        return {clamp_vel(r[4*WORD_W-1:3*WORD_W]),
                clamp_vel(r[3*WORD_W-1:2*WORD_W]),
                r[2*WORD_W-1:0]};
    endfunction
`else
    function automatic logic [REC_W-1:0] latch_rec(input logic [REC_W-1:0] r);
        return r;
    endfunction
`endif

    logic [NUM_BOTS-1:0]            hold_valid_q, hold_valid_d;
    logic [NUM_BOTS-1:0][REC_W-1:0] hold_data_q, hold_data_d;
    logic [NUM_BOTS-1:0]            slot_busy_q, slot_busy_d;
    logic                           proto_err_q, proto_err_d;

    wr_state_e                      state_q, state_d;
    logic [2:0]                     grant_q, grant_d;
    logic                           wr_valid_q, wr_valid_d;
    logic [5:0]                     wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]              wr_data_q, wr_data_d;
    logic                           write_done_q, write_done_d;
    logic [2:0]                     done_bot_q, done_bot_d;

    logic [NUM_BOTS-1:0]            cand;
    logic                           gnt_valid;
    logic [2:0]                     gnt_idx;
    logic                           arb_adv;
    logic                           commit_fire;
    logic [REC_W-1:0]               cur_rec;
    logic [REC_W-1:0]               gnt_rec;

    assign cand        = hold_valid_q & ~slot_busy_q;
    assign arb_adv     = (state_q == ST_IDLE);
    assign commit_fire = (state_q == ST_COMMIT) && wr_ready;

    rr_arbiter #(
        .N (NUM_BOTS)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (cand),
        .adv       (arb_adv),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Mux out the in-flight record and the newly granted record.
    always_comb begin
        cur_rec = '0;
        gnt_rec = '0;
        for (int i = 0; i < NUM_BOTS; i++) begin
            if (grant_q == 3'(i)) begin
                cur_rec = hold_data_q[i];
            end
            if (gnt_idx == 3'(i)) begin
                gnt_rec = hold_data_q[i];
            end
        end
    end

    // Holding registers, slot occupancy and the sticky protocol error.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        slot_busy_d  = slot_busy_q;
        proto_err_d  = proto_err_q;
        for (int i = 0; i < NUM_BOTS; i++) begin
            if (upd_valid[i] && !hold_valid_q[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_data_d[i]  = latch_rec(upd_data[64*i +: REC_W]);
            end
            if (commit_fire && grant_q == 3'(i)) begin
                hold_valid_d[i] = 1'b0;
                slot_busy_d[i]  = 1'b1;
            end
            if (slot_consumed[i]) begin
                if (slot_busy_q[i]) begin
                    slot_busy_d[i] = 1'b0;
                end else begin
                    proto_err_d = 1'b1;
                end
            end
        end
    end

    // Writer FSM next-state and next-output; outputs hold while the bus stalls.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        wr_valid_d   = wr_valid_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        write_done_d = 1'b0;
        done_bot_d   = done_bot_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    grant_d    = gnt_idx;
                    state_d    = ST_WR_VX;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = {gnt_idx, WORD_VX};
                    wr_data_d  = rec_word(gnt_rec, WORD_VX);
                end
            end
            ST_WR_VX: begin
                if (wr_ready) begin
                    state_d   = ST_WR_VY;
                    wr_addr_d = {grant_q, WORD_VY};
                    wr_data_d = rec_word(cur_rec, WORD_VY);
                end
            end
            ST_WR_VY: begin
                if (wr_ready) begin
                    state_d   = ST_WR_X;
                    wr_addr_d = {grant_q, WORD_X};
                    wr_data_d = rec_word(cur_rec, WORD_X);
                end
            end
            ST_WR_X: begin
                if (wr_ready) begin
                    state_d   = ST_WR_Y;
                    wr_addr_d = {grant_q, WORD_Y};
                    wr_data_d = rec_word(cur_rec, WORD_Y);
                end
            end
            ST_WR_Y: begin
                if (wr_ready) begin
                    state_d   = ST_COMMIT;
                    wr_addr_d = {grant_q, WORD_FLAG};
                    wr_data_d = WORD_W'(FLAG_W);
                end
            end
            ST_COMMIT: begin
                if (wr_ready) begin
                    state_d      = ST_IDLE;
                    wr_valid_d   = 1'b0;
                    wr_addr_d    = 6'd0;
                    wr_data_d    = '0;
                    write_done_d = 1'b1;
                    done_bot_d   = grant_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wr_valid_d = 1'b0;
                wr_addr_d  = 6'd0;
                wr_data_d  = '0;
            end
        endcase
    end

    // Single state/output register; reset abandons any record in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= '0;
            hold_data_q  <= '0;
            slot_busy_q  <= '0;
            proto_err_q  <= 1'b0;
            state_q      <= ST_IDLE;
            grant_q      <= 3'd0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= 6'd0;
            wr_data_q    <= '0;
            write_done_q <= 1'b0;
            done_bot_q   <= 3'd0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            slot_busy_q  <= slot_busy_d;
            proto_err_q  <= proto_err_d;
            state_q      <= state_d;
            grant_q      <= grant_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            write_done_q <= write_done_d;
            done_bot_q   <= done_bot_d;
        end
    end

    assign upd_ready  = ~hold_valid_q;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign write_done = write_done_q;
    assign done_bot   = done_bot_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_bot_state_writer.sv
// Directed bench for bot_state_writer: reset values, single record timing,
// busy-slot stall, round-robin fairness, bus backpressure, reset mid-record
// with the protocol error, and the velocity word path (clamped or bit-exact
// depending on BOT_VEL_CLAMP_EN).
`timescale 1ns/1ps
module tb_bot_state_writer;

    localparam int N = 3;

    logic            clk;
    logic            rst;
    logic [N-1:0]    upd_valid;
    logic [N-1:0]    upd_ready;
    logic [N*64-1:0] upd_data;
    logic            wr_valid;
    logic            wr_ready;
    logic [5:0]      wr_addr;
    logic [15:0]     wr_data;
    logic [N-1:0]    slot_consumed;
    logic            write_done;
    logic [2:0]      done_bot;
    logic            proto_err;

    int checks   = 0;
    int failures = 0;

    bot_state_writer #(
        .NUM_BOTS (N),
        .WORD_W   (16),
        .VMAX     (16'h1000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_data      (upd_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .slot_consumed (slot_consumed),
        .write_done    (write_done),
        .done_bot      (done_bot),
        .proto_err     (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs set afterwards apply to the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rec(input logic [15:0] vx, input logic [15:0] vy,
                                        input logic [15:0] x, input logic [15:0] y);
        return {vx, vy, x, y};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        upd_valid = '0;
        slot_consumed = '0;
        wr_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Offer one record for bot b during cycle 0; returns in cycle 1.
    task automatic offer(input int b, input logic [63:0] r);
        upd_data[b*64 +: 64] = r;
        upd_valid[b] = 1'b1;
        tick();
        upd_valid[b] = 1'b0;
    endtask

    task automatic consume(input logic [N-1:0] m);
        slot_consumed = m;
        tick();
        slot_consumed = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (upd_ready !== 3'b111) begin failures++; $display("FAIL reset_upd_ready got=%b exp=111", upd_ready); end
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
        checks++; if (wr_addr !== 6'd0) begin failures++; $display("FAIL reset_wr_addr got=%o exp=0", wr_addr); end
        checks++; if (wr_data !== 16'h0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0000", wr_data); end
        checks++; if (write_done !== 1'b0) begin failures++; $display("FAIL reset_write_done got=%b exp=0", write_done); end
        checks++; if (done_bot !== 3'd0) begin failures++; $display("FAIL reset_done_bot got=%0d exp=0", done_bot); end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
    endtask

    task automatic test_single_record();
        logic [5:0]  ea [5];
        logic [15:0] ed [5];
        ea = '{6'o11, 6'o12, 6'o13, 6'o14, 6'o10};
        ed = '{16'h0400, 16'hFC00, 16'h0800, 16'h1800, 16'h0077};
        offer(1, rec(16'h0400, 16'hFC00, 16'h0800, 16'h1800));
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL single_c1_valid got=%b exp=0", wr_valid); end
        checks++; if (upd_ready[1] !== 1'b0) begin failures++; $display("FAIL single_upd_ready got=%b exp=0", upd_ready[1]); end
        for (int c = 2; c <= 6; c++) begin
            tick();
            checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL single_valid c=%0d got=%b exp=1", c, wr_valid); end
            checks++; if (wr_addr !== ea[c-2]) begin failures++; $display("FAIL single_addr c=%0d got=%o exp=%o", c, wr_addr, ea[c-2]); end
            checks++; if (wr_data !== ed[c-2]) begin failures++; $display("FAIL single_data c=%0d got=%h exp=%h", c, wr_data, ed[c-2]); end
        end
        tick();
        checks++; if (write_done !== 1'b1) begin failures++; $display("FAIL single_done got=%b exp=1", write_done); end
        checks++; if (done_bot !== 3'd1) begin failures++; $display("FAIL single_done_bot got=%0d exp=1", done_bot); end
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL single_c7_valid got=%b exp=0", wr_valid); end
        tick();
        checks++; if (write_done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0", write_done); end
    endtask

    // Slot 1 is still 'w' from the previous record, so the new one must wait.
    task automatic test_busy_slot();
        offer(1, rec(16'h1111, 16'h2222, 16'h3333, 16'h4444));
        for (int c = 1; c <= 10; c++) begin
            checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL busy_stall c=%0d got=%b exp=0", c, wr_valid); end
            tick();
        end
        consume(3'b010);
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL busy_grant_cycle got=%b exp=0", wr_valid); end
        tick();
        checks++; if (wr_valid !== 1'b1 || wr_addr !== 6'o11 || wr_data !== 16'h1111) begin
            failures++; $display("FAIL busy_vx got=%b/%o/%h exp=1/11/1111", wr_valid, wr_addr, wr_data);
        end
        for (int c = 0; c < 5; c++) tick();
        checks++; if (write_done !== 1'b1 || done_bot !== 3'd1) begin
            failures++; $display("FAIL busy_done got=%b/%0d exp=1/1", write_done, done_bot);
        end
        consume(3'b010);
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL busy_proto_err got=%b exp=0", proto_err); end
    endtask

    task automatic test_fairness();
        logic [15:0] dat [3][4];
        int p, b;
        logic [2:0]  w;
        logic [15:0] ed;
        dat = '{'{16'h0100, 16'h0200, 16'h0300, 16'h0400},
                '{16'h1100, 16'h1200, 16'h1300, 16'h1400},
                '{16'h2100, 16'h2200, 16'h2300, 16'h2400}};
        do_reset();
        for (int i = 0; i < 3; i++) upd_data[i*64 +: 64] = rec(dat[i][0], dat[i][1], dat[i][2], dat[i][3]);
        upd_valid = 3'b111;
        tick();
        upd_valid = '0;
        for (int c = 1; c <= 20; c++) begin
            if (c >= 2) begin
                p = (c - 2) % 6;
                b = (c - 2) / 6;
            end else begin
                p = 5;
                b = 0;
            end
            if (b < 3 && p < 5) begin
                w  = (p < 4) ? 3'(p + 1) : 3'd0;
                ed = (p < 4) ? dat[b][p] : 16'h0077;
                checks++; if (wr_valid !== 1'b1 || wr_addr !== {3'(b), w} || wr_data !== ed) begin
                    failures++; $display("FAIL fair_beat c=%0d got=%b/%o/%h exp=1/%o/%h", c, wr_valid, wr_addr, wr_data, {3'(b), w}, ed);
                end
            end else begin
                checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL fair_gap c=%0d got=%b exp=0", c, wr_valid); end
            end
            if (c == 7 || c == 13 || c == 19) begin
                checks++; if (write_done !== 1'b1 || done_bot !== 3'((c - 7) / 6)) begin
                    failures++; $display("FAIL fair_done c=%0d got=%b/%0d exp=1/%0d", c, write_done, done_bot, (c - 7) / 6);
                end
            end else begin
                checks++; if (write_done !== 1'b0) begin failures++; $display("FAIL fair_nodone c=%0d got=%b exp=0", c, write_done); end
            end
            tick();
        end
        consume(3'b111);
    endtask

    task automatic test_backpressure();
        logic [5:0]  ea [8];
        logic [15:0] ed [8];
        logic        rd [8];
        int beats = 0;
        ea = '{6'o21, 6'o22, 6'o23, 6'o23, 6'o23, 6'o23, 6'o24, 6'o20};
        ed = '{16'hA001, 16'hA002, 16'hA003, 16'hA003, 16'hA003, 16'hA003, 16'hA004, 16'h0077};
        rd = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        offer(2, rec(16'hA001, 16'hA002, 16'hA003, 16'hA004));
        tick();
        for (int c = 2; c <= 9; c++) begin
            wr_ready = rd[c-2];
            checks++; if (wr_valid !== 1'b1 || wr_addr !== ea[c-2] || wr_data !== ed[c-2]) begin
                failures++; $display("FAIL bp_beat c=%0d got=%b/%o/%h exp=1/%o/%h", c, wr_valid, wr_addr, wr_data, ea[c-2], ed[c-2]);
            end
            if (wr_valid && wr_ready) beats++;
            tick();
        end
        wr_ready = 1'b1;
        checks++; if (write_done !== 1'b1 || done_bot !== 3'd2 || wr_valid !== 1'b0) begin
            failures++; $display("FAIL bp_done got=%b/%0d/%b exp=1/2/0", write_done, done_bot, wr_valid);
        end
        checks++; if (beats !== 5) begin failures++; $display("FAIL bp_beat_count got=%0d exp=5", beats); end
        consume(3'b100);
    endtask

    task automatic test_reset_mid_record();
        offer(0, rec(16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04));
        tick();
        tick();
        checks++; if (wr_valid !== 1'b1 || wr_addr !== 6'o02) begin
            failures++; $display("FAIL mid_vy got=%b/%o exp=1/02", wr_valid, wr_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", wr_valid); end
        checks++; if (upd_ready !== 3'b111) begin failures++; $display("FAIL mid_rst_ready got=%b exp=111", upd_ready); end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL mid_no_beat c=%0d got=%b/%o exp=0", c, wr_valid, wr_addr); end
        end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL mid_err_pre got=%b exp=0", proto_err); end
        consume(3'b001);
        for (int c = 0; c < 4; c++) begin
            checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL mid_err_sticky c=%0d got=%b exp=1", c, proto_err); end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL mid_err_clear got=%b exp=0", proto_err); end
    endtask

    // Velocity words beyond +/-2.0: saturated when the clamp is built in,
    // bit-exact otherwise. Position words are never altered.
    task automatic test_vel_words();
        logic [15:0] ed [4];
`ifdef BOT_VEL_CLAMP_EN
        ed = '{16'h1000, 16'hF000, 16'h7FFF, 16'h8000};
`else
        ed = '{16'h3000, 16'hC000, 16'h7FFF, 16'h8000};
`endif
        do_reset();
        offer(0, rec(16'h3000, 16'hC000, 16'h7FFF, 16'h8000));
        for (int c = 2; c <= 5; c++) begin
            tick();
            checks++; if (wr_valid !== 1'b1 || wr_addr !== {3'd0, 3'(c - 1)} || wr_data !== ed[c-2]) begin
                failures++; $display("FAIL vel_word c=%0d got=%b/%o/%h exp=1/%o/%h", c, wr_valid, wr_addr, wr_data, {3'd0, 3'(c - 1)}, ed[c-2]);
            end
        end
        tick();
        checks++; if (wr_data !== 16'h0077 || wr_addr !== 6'o00) begin
            failures++; $display("FAIL vel_flag got=%o/%h exp=00/0077", wr_addr, wr_data);
        end
    endtask

    initial begin
        rst = 1'b1;
        upd_valid = '0;
        upd_data = '0;
        wr_ready = 1'b1;
        slot_consumed = '0;
        test_reset();
        test_single_record();
        test_busy_slot();
        test_fairness();
        test_backpressure();
        test_reset_mid_record();
        test_vel_words();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
